// File: rtl/mem_arbiter.sv
// Port-A arbiter for the Chip-8 RAM: CPU vs. host loader, one access at a time,
// IDLE -> ISSUE -> DONE sequencing with read data taken from the RAM's registered output.
module mem_arbiter #(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_write,
  input  logic [11:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [7:0]  ldr_rdata,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        wp_hit
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef struct packed {
    logic        write;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [7:0] cpu_rdata_q, ldr_rdata_q;
  logic       grant_ldr;
  req_t       cpu_cmd, ldr_cmd, sel_cmd;

  assign cpu_cmd = '{write: cpu_write, addr: cpu_addr, wdata: cpu_wdata};
  assign ldr_cmd = '{write: ldr_write, addr: ldr_addr, wdata: ldr_wdata};

  // On a tie the loader wins only in round-robin mode and only if the CPU went last.
  always_comb begin
    grant_ldr = ldr_req;
    if (cpu_req && ldr_req)
      grant_ldr = !CPU_PRIORITY && (last_grant == OWN_CPU);
  end

  assign sel_cmd = grant_ldr ? ldr_cmd : cpu_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      last_grant  <= OWN_LDR;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req || ldr_req) begin
          state     <= ISSUE;
          owner     <= grant_ldr ? OWN_LDR : OWN_CPU;
          mem_write <= sel_cmd.write;
          mem_addr  <= sel_cmd.addr;
          mem_wdata <= sel_cmd.wdata;
        end
        ISSUE: state <= DONE;
        DONE: begin
          state      <= IDLE;
          last_grant <= owner;
          // Writes return the old byte too: the RAM reads before it writes.
          if (owner == OWN_CPU) cpu_rdata_q <= mem_rdata;
          else                  ldr_rdata_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en  = (state == ISSUE);
  assign busy    = (state != IDLE);
  assign cpu_ack = (state == DONE) && (owner == OWN_CPU);
  assign ldr_ack = (state == DONE) && (owner == OWN_LDR);
  assign wp_hit  = (state == DONE) && mem_write && (mem_addr[11:9] == 3'd0);

  // RAM output is already registered, so forward it during the ack cycle and hold after.
  assign cpu_rdata = cpu_ack ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = ldr_ack ? mem_rdata : ldr_rdata_q;
endmodule
